mem_stage: RTL

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. Consumes the EXE→MEM bus and issues at most one load or store per instruction to the data cache over a req/addr_ok/data_ok handshake. Aligns and extends load data, produces the MEM→WB bus, and exports forwarding and load-use information back to execute.

---
 rtl/mem_stage.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage; single-request data-cache handshake, load alignment, MEM->WB bus.
// Optional define MEM_UNALIGNED_EXC_EN traps misaligned word accesses instead of issuing them.
module mem_stage (
   input  logic         clk,
   input  logic         resetn,
   input  logic         MEM_valid,
   input  logic         MEM_go,
   input  logic [154:0] EXE_MEM_bus_r,
   output logic         data_req,
   output logic         data_wr,
   output logic [3:0]   data_wstrb,
   output logic [31:0]  data_addr,
   output logic [31:0]  data_wdata,
   input  logic         data_addr_ok,
   input  logic         data_data_ok,
   input  logic [31:0]  data_rdata,
   output logic         MEM_over,
   output logic [117:0] MEM_WB_bus,
   output logic [4:0]   MEM_wdest,
   output logic [31:0]  MEM_fwd_wdata,
   output logic         MEM_load_pending,
   output logic         mem_addr_exc,
   output logic [31:0]  bad_vaddr
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

   state_e      state_q, state_d;
   logic [31:0] rdata_q;

   // Low 54 bits of the EXE bus: {hi_write..eret (16), rf_wen, rf_wdest, pc}.
   logic        ld, st, word, sgn;
   logic [31:0] store_data, exe_result, lo_result, pc;
   logic [15:0] misc_ctrl;
   logic        rf_wen_in;
   logic [4:0]  rf_wdest;
   logic        unused_bus_bit;

   assign {ld, st, word, sgn} = EXE_MEM_bus_r[153:150];
   assign store_data          = EXE_MEM_bus_r[149:118];
   assign exe_result          = EXE_MEM_bus_r[117:86];
   assign lo_result           = EXE_MEM_bus_r[85:54];
   assign misc_ctrl           = EXE_MEM_bus_r[53:38];
   assign rf_wen_in           = EXE_MEM_bus_r[37];
   assign rf_wdest            = EXE_MEM_bus_r[36:32];
   assign pc                  = EXE_MEM_bus_r[31:0];
   assign unused_bus_bit      = EXE_MEM_bus_r[154];

   logic mem_op, misaligned;
   assign mem_op = ld | st;

`ifdef MEM_UNALIGNED_EXC_EN
   assign misaligned   = mem_op & word & (exe_result[1:0] != 2'b00);
   assign mem_addr_exc = MEM_valid & misaligned;
   assign bad_vaddr    = mem_addr_exc ? exe_result : 32'd0;
`else
   assign misaligned   = 1'b0;
   assign mem_addr_exc = 1'b0;
   assign bad_vaddr    = 32'd0;
`endif

   // NOTE: every always_comb assigns its outputs a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (MEM_valid & mem_op & ~misaligned) state_d = S_REQ;
         S_REQ:   if (data_addr_ok) state_d = S_WAIT;
         S_WAIT:  if (data_data_ok) state_d = S_DONE;
         S_DONE:  state_d = S_DONE;
         default: state_d = S_IDLE;
      endcase
      if (MEM_go) state_d = S_IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments and resets asynchronously on resetn low.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if ((state_q == S_WAIT) && data_data_ok) rdata_q <= data_rdata;
      end
   end

   // The bus register is frozen while the instruction sits in MEM, so the request fields stay stable.
   assign data_req   = (state_q == S_REQ);
   assign data_wr    = st;
   assign data_addr  = word ? {exe_result[31:2], 2'b00} : exe_result;
   assign data_wdata = word ? store_data : {4{store_data[7:0]}};

   always_comb begin
      data_wstrb = 4'b0000;
      if (st) data_wstrb = word ? 4'b1111 : (4'b0001 << exe_result[1:0]);
   end

   logic [7:0]  load_byte;
   logic [31:0] mem_result;

   always_comb begin
      load_byte = rdata_q[7:0];
      case (exe_result[1:0])
         2'd1:    load_byte = rdata_q[15:8];
         2'd2:    load_byte = rdata_q[23:16];
         2'd3:    load_byte = rdata_q[31:24];
         default: load_byte = rdata_q[7:0];
      endcase

      mem_result = exe_result;
      if (ld & ~st & ~misaligned) begin
         if (word) mem_result = rdata_q;
         else      mem_result = {{24{sgn & load_byte[7]}}, load_byte};
      end
   end

   logic rf_wen_out;
   assign rf_wen_out = rf_wen_in & ~misaligned;

   assign MEM_over         = MEM_valid & (~mem_op | (state_q == S_DONE) | mem_addr_exc);
   assign MEM_WB_bus       = {rf_wen_out, rf_wdest, mem_result, lo_result, misc_ctrl, pc};
   assign MEM_wdest        = rf_wdest & {5{MEM_valid}};
   assign MEM_fwd_wdata    = mem_result;
   assign MEM_load_pending = MEM_valid & ld & (state_q != S_DONE);

endmodule
